// File: rtl/dw_weight_sched_pkg.sv
// Shared types and sizing helpers for the depthwise weight-fetch scheduler.
package dw_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETADDR = 3'd1,
        S_LOAD    = 3'd2,
        S_FILL    = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic int unsigned nwords(input int unsigned ksize);
        return ksize * ksize;
    endfunction

    // Bytes occupied by one channel's kernel in the weight buffer.
    function automatic int unsigned stride(input int unsigned ksize, input int unsigned dw);
        return ksize * ksize * (dw / 8);
    endfunction

    localparam int unsigned DEF_KSIZE = 3;
    localparam int unsigned BEAT_CW   = $clog2(nwords(DEF_KSIZE) + 1);

endpackage

// File: rtl/dw_weight_sched_if.sv
// Layer-controller / weight-buffer / PE signal bundle for the scheduler.
interface dw_weight_sched_if
    import dw_sched_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned CHW = 10
) ();
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [CHW-1:0] num_ch;
    logic           rvalid;
    logic           ch_done;
    logic [AW-1:0]  init_addr;
    logic           init_addr_en;
    logic           weight_load;
    logic           w_valid;
    logic [CHW-1:0] cur_ch;
    logic           busy;
    logic           layer_done;
    logic           err_beat;

    modport master (
        output start, base_addr, num_ch, rvalid, ch_done,
        input  init_addr, init_addr_en, weight_load, w_valid, cur_ch, busy, layer_done, err_beat
    );

    modport slave (
        input  start, base_addr, num_ch, rvalid, ch_done,
        output init_addr, init_addr_en, weight_load, w_valid, cur_ch, busy, layer_done, err_beat
    );
endinterface

// File: rtl/dw_weight_sched_beat_cnt.sv
// Read-beat counter: clear, increment, flag the beat that completes one kernel.
module dw_beat_cnt
    import dw_sched_pkg::*;
#(
    parameter int unsigned NWORDS = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last_beat_c
);
    localparam int unsigned    CW   = $clog2(NWORDS + 1);
    localparam logic [CW-1:0]  LAST = CW'(NWORDS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)      r_cnt <= '0;
        else if (i_clr)  r_cnt <= '0;
        else if (i_inc)  r_cnt <= r_cnt + CW'(1);
    end

    assign o_last_beat_c = i_inc && (r_cnt == LAST);
endmodule

// File: rtl/dw_weight_sched.sv
// Per-layer weight-fetch scheduler: walks channels, programs address, loads and holds one kernel each.
module dw_weight_sched
    import dw_sched_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned KSIZE = 3,
    parameter int unsigned CHW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    dw_weight_sched_if.slave  bus
);
    localparam int unsigned   NWORDS = nwords(KSIZE);
    localparam logic [AW-1:0] STRIDE = AW'(stride(KSIZE, DW));

    state_t         r_state, w_state_n;
    logic [AW-1:0]  r_addr, w_addr_n;
    logic [AW-1:0]  r_init_addr, w_init_addr_n;
    logic [CHW-1:0] r_num_ch, w_num_ch_n;
    logic [CHW-1:0] r_cur_ch, w_cur_ch_n;
    logic           r_err, w_err_n;
    logic           r_init_addr_en, r_weight_load, r_w_valid, r_busy, r_layer_done;
    logic           w_beat_clr, w_beat_inc, w_last_beat, w_last_ch;

    assign w_beat_clr = (r_state == S_LOAD);
    assign w_beat_inc = (r_state == S_FILL) && bus.rvalid;
    assign w_last_ch  = (r_cur_ch == (r_num_ch - CHW'(1)));

    dw_beat_cnt #(.NWORDS(NWORDS)) u_beat_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_beat_clr),
        .i_inc         (w_beat_inc),
        .o_last_beat_c (w_last_beat)
    );

    // Next-state, address accumulator and sticky error.
    always_comb begin
        w_state_n  = r_state;
        w_addr_n   = r_addr;
        w_num_ch_n = r_num_ch;
        w_cur_ch_n = r_cur_ch;
        w_err_n    = r_err;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_addr_n   = bus.base_addr;
                    w_num_ch_n = bus.num_ch;
                    w_cur_ch_n = '0;
                    w_err_n    = 1'b0;
                    w_state_n  = (bus.num_ch == '0) ? S_DONE : S_SETADDR;
                end
            end
            S_SETADDR: w_state_n = S_LOAD;
            S_LOAD:    w_state_n = S_FILL;
            S_FILL:    if (w_last_beat) w_state_n = S_HOLD;
            S_HOLD: begin
                if (bus.ch_done) begin
                    if (w_last_ch) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_cur_ch_n = r_cur_ch + CHW'(1);
                        w_addr_n   = r_addr + STRIDE;
                        w_state_n  = S_SETADDR;
                    end
                end
            end
            S_DONE:    w_state_n = S_IDLE;
            default:   w_state_n = S_IDLE;
        endcase
        if (bus.rvalid && (r_state != S_FILL)) w_err_n = 1'b1;
        w_init_addr_n = (w_state_n == S_SETADDR) ? w_addr_n : r_init_addr;
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_init_addr    <= '0;
            r_num_ch       <= '0;
            r_cur_ch       <= '0;
            r_err          <= 1'b0;
            r_init_addr_en <= 1'b0;
            r_weight_load  <= 1'b0;
            r_w_valid      <= 1'b0;
            r_busy         <= 1'b0;
            r_layer_done   <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_addr         <= w_addr_n;
            r_init_addr    <= w_init_addr_n;
            r_num_ch       <= w_num_ch_n;
            r_cur_ch       <= w_cur_ch_n;
            r_err          <= w_err_n;
            r_init_addr_en <= (w_state_n == S_SETADDR);
            r_weight_load  <= (w_state_n == S_LOAD);
            r_w_valid      <= (w_state_n == S_HOLD);
            r_busy         <= (w_state_n != S_IDLE);
            r_layer_done   <= (w_state_n == S_DONE);
        end
    end

    assign bus.init_addr    = r_init_addr;
    assign bus.init_addr_en = r_init_addr_en;
    assign bus.weight_load  = r_weight_load;
    assign bus.w_valid      = r_w_valid;
    assign bus.cur_ch       = r_cur_ch;
    assign bus.busy         = r_busy;
    assign bus.layer_done   = r_layer_done;
    assign bus.err_beat     = r_err;
endmodule

// File: doc/dw_weight_sched.md
# dw_weight_sched

Per-layer weight-fetch scheduler for the depthwise convolution path. On a layer start it walks the output channels one at a time. For each channel it programs the weight buffer's start address, triggers a weight load, counts the returning read beats until one KSIZE×KSIZE kernel is resident, then holds the kernel for the PE array until the PE reports the channel finished. It sits between the layer controller and the weight buffer (address-init / load-trigger side, plus a monitor tap on the read-data valid).

## Interface
Parameters:
- DW, 32, weight word width in bits; must be a multiple of 8
- AW, 32, byte address width
- KSIZE, 3, kernel side; words per channel NWORDS = KSIZE*KSIZE
- CHW, 10, channel-count width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  layer start pulse; sampled only in IDLE
- base_addr  in  AW  byte address of channel 0 kernel; sampled with start
- num_ch  in  CHW  number of channels; sampled with start
- init_addr  out  AW  kernel start address presented to the weight buffer
- init_addr_en  out  1  one-cycle strobe qualifying init_addr
- weight_load  out  1  one-cycle load trigger to the weight buffer
- rvalid  in  1  read-data valid, monitored only (not consumed)
- w_valid  out  1  current channel kernel fully resident
- cur_ch  out  CHW  index of the channel being fetched or held
- ch_done  in  1  PE finished current channel; honoured only while w_valid=1
- busy  out  1  high from the cycle after an accepted start through DONE
- layer_done  out  1  one-cycle pulse at end of layer
- err_beat  out  1  sticky: rvalid seen outside FILL; cleared by reset or accepted start

## Operation
- States: IDLE, SETADDR, LOAD, FILL, HOLD, DONE.
- IDLE: start=1 latches base_addr and num_ch, clears cur_ch and err_beat.
  - num_ch=0 → DONE.
  - Otherwise → SETADDR.
- start outside IDLE is ignored.
- SETADDR: init_addr_en=1; init_addr = base + cur_ch*STRIDE, where STRIDE = NWORDS*(DW/8) bytes. Arithmetic is modulo 2^AW; wrap is silent. → LOAD.
- LOAD: weight_load=1; beat counter cleared. → FILL.
- FILL: each rvalid increments the beat counter, width $clog2(NWORDS+1). On the rvalid that makes the count NWORDS → HOLD.
- HOLD: w_valid=1. On ch_done:
  - If cur_ch = num_ch−1 → DONE.
  - Otherwise cur_ch+1 → SETADDR.
- DONE: layer_done=1 for one cycle. → IDLE.
- rvalid in any state other than FILL sets err_beat. This includes rvalid in the same cycle as ch_done. FSM behaviour is unchanged.
- ch_done outside HOLD is ignored.
- Reset, including mid-layer: next state IDLE, all counters 0, err_beat 0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from input to output.
- Reset values:
  - init_addr = 0.
  - init_addr_en, weight_load, w_valid, busy, layer_done, err_beat = 0.
  - cur_ch = 0.
- start sampled at cycle T → init_addr_en at T+1, weight_load at T+2, FILL from T+3.
- busy high from T+1 through the DONE cycle; low from the cycle IDLE is re-entered.
- Last (NWORDS-th) rvalid sampled at cycle F → w_valid=1 from F+1.
- ch_done sampled at cycle H (w_valid=1) → w_valid=0 at H+1. Also at H+1, either init_addr_en for the next channel or layer_done. IDLE at H+2 after DONE.
- Per-channel overhead excluding fetch latency: 3 cycles (SETADDR, LOAD, HOLD→SETADDR).
- num_ch=0: start at T → layer_done at T+1, no init_addr_en or weight_load.
- init_addr holds its value between strobes.

## Structure
- Shared package dw_sched_pkg:
  - State enum.
  - Functions nwords(KSIZE) and stride(KSIZE, DW).
  - Localparam for beat-counter width.
- One natural sub-module: dw_beat_cnt. It holds the clear/increment/terminal-count beat counter, is parameterised by NWORDS, and outputs last_beat.
- The address step is an accumulator: add STRIDE on each channel advance. It does not use a multiplier.

## Test plan
- base_addr=0x1000, num_ch=3, DW=32, KSIZE=3, 9 rvalid per channel, ch_done 5 cycles after w_valid → init_addr 0x1000, 0x1024, 0x1048; cur_ch 0,1,2; one layer_done; err_beat=0.
- num_ch=0, start → layer_done at T+1; no init_addr_en or weight_load; busy high exactly one cycle.
- base_addr=0xFFFF_FFF0, num_ch=2 → init_addr 0xFFFF_FFF0 then 0x0000_0014 (wrap).
- rvalid asserted during HOLD, including the same cycle as ch_done → err_beat sets and stays set; channel sequence unchanged; next accepted start clears it.
- start pulsed during FILL and ch_done pulsed during FILL → both ignored; w_valid only after the 9th beat.
- rst_n low for 1 cycle during FILL of channel 1 → all outputs at reset values next cycle; a subsequent start restarts at cur_ch=0 with init_addr=base_addr.
